prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter p_size, default 6, program memory address width.
REQ-002 Parameter i_size, default 24, instruction width; SHALL be a multiple of 8.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a load; sampled only in IDLE.
REQ-006 len  input  p_size+1  number of instructions to load, sampled with start.
REQ-007 rx_data  input  8  instruction byte, MSB-first within each instruction.
REQ-008 rx_valid  input  1  rx_data valid.
REQ-009 rx_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  program memory write enable, one-cycle pulse per instruction.
REQ-011 mem_addr  output  p_size  write address.
REQ-012 mem_wdata  output  i_size  assembled instruction.
REQ-013 busy  output  1  high in every state except IDLE; holds the CPU off the program memory.
REQ-014 done  output  1  one-cycle pulse at load completion.
REQ-015 words_loaded  output  p_size+1  instructions written since last accepted start; holds after done.

Function
REQ-016 Constant BYTES = i_size/8 (3 at default).
REQ-017 States IDLE, RECV, WRITE, DONE; registered state, Moore outputs.
REQ-018 IDLE: rx_ready=0, mem_we=0; start=1 with len!=0 -> RECV, clear address, byte count, words_loaded; start=1 with len=0 -> DONE, clear words_loaded.
REQ-019 len greater than 2^p_size SHALL be treated as 2^p_size.
REQ-020 RECV: rx_ready=1; byte accepted only when rx_valid && rx_ready; assembly register shifts left 8 bits with rx_data into the low byte; byte count increments.
REQ-021 On acceptance of byte BYTES-1 of a word: -> WRITE next cycle; byte count wraps to 0.
REQ-022 rx_valid low in RECV: no state change, no data change (stalls indefinitely).
REQ-023 WRITE: rx_ready=0, mem_we=1 for exactly one cycle, mem_wdata = assembled word, mem_addr = current address; words_loaded increments.
REQ-024 WRITE exit: if address == effective len-1 -> DONE, else address+1 -> RECV.
REQ-025 Latency: mem_we asserts the cycle after the final byte handshake of a word; done asserts the cycle after the final mem_we.
REQ-026 DONE: done=1, busy=1, rx_ready=0 for one cycle -> IDLE.
REQ-027 start while not IDLE SHALL be ignored.
REQ-028 mem_addr SHALL never exceed 2^p_size-1; no wrap within one load.
REQ-029 mem_wdata SHALL hold its value outside WRITE; mem_we=0 outside WRITE.

Reset
REQ-030 Reset=1 SHALL force IDLE, rx_ready=0, mem_we=0, busy=0, done=0, mem_addr=0, mem_wdata=0, words_loaded=0, byte count=0 at the next edge.
REQ-031 Reset mid-load SHALL discard any partial word with no write; already written words remain in memory.
REQ-032 Reset has priority over start and over any rx handshake in the same cycle.

Structure
REQ-033 Package prog_pkg SHALL hold P_SIZE, I_SIZE, BYTES_PER_INSTR and the state enum typedef loader_state_t.
REQ-034 One sub-module instr_assembler (shift register plus byte counter, emitting word_ready) is natural; the FSM stays in prog_loader.
REQ-035 Output drives a writable program memory with a single synchronous write port; reads are unchanged.

Verification
REQ-036 Reset, start, len=2, bytes 12 34 56 AB CD EF with rx_valid held high -> writes 0x123456 @0 then 0xABCDEF @1, done one cycle after second mem_we, words_loaded=2.
REQ-037 len=1, rx_valid toggled low between every byte -> single write 0x123456 @0 only after third handshake; rx_ready high throughout RECV.
REQ-038 start with len=0 -> DONE next cycle, done pulse, no mem_we, words_loaded=0.
REQ-039 len=64, 192 bytes -> addresses 0..63 written in order, mem_addr never 64; len=100 -> identical 64-write behaviour.
REQ-040 Reset asserted after 2 bytes of word 1 (len=3) -> no write of partial word, all outputs at reset values; new start reloads from address 0.
REQ-041 start pulsed during RECV and WRITE -> no effect on address, byte count or words_loaded.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared constants and types for the program loader.
// Default sizes match a 64-entry, 24-bit program memory.
package prog_pkg;

    localparam int unsigned P_SIZE          = 6;
    localparam int unsigned I_SIZE          = 24;
    localparam int unsigned BYTES_PER_INSTR = I_SIZE / 8;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone
    } loader_state_t;

    // Counter width that stays legal when only one byte per word is needed.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_assembler.sv
// Byte-to-instruction assembler: MSB-first shift register plus a byte counter.
// word_ready pulses on the handshake that completes a word; word is the completed value.
module instr_assembler
    import prog_pkg::*;
#(
    parameter int unsigned nbytes = BYTES_PER_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            data,
    output logic [nbytes*8-1:0]   word,
    output logic                  word_ready
);

    localparam int unsigned Width   = nbytes * 8;
    localparam int unsigned CntW    = cnt_width(nbytes);
    localparam logic [CntW-1:0] LastCnt = CntW'(nbytes - 1);

    logic [Width-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] shifted;

    assign shifted    = (shift_q << 8) | Width'(data);
    assign word       = shifted;
    assign word_ready = accept && !clear && (cnt_q == LastCnt);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (accept) begin
            shift_d = shifted;
            cnt_d   = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams bytes from a serial source into a writable program memory, one
// instruction per write, holding the CPU off the memory while busy.
module prog_loader
    import prog_pkg::*;
#(
    parameter int unsigned p_size = P_SIZE,
    parameter int unsigned i_size = I_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [p_size:0]   len,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [p_size-1:0] mem_addr,
    output logic [i_size-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [p_size:0]   words_loaded
);

    localparam logic [p_size:0] MaxLen = {1'b1, {p_size{1'b0}}};

    loader_state_t     state_q, state_d;
    logic [p_size-1:0] addr_q;
    logic [p_size-1:0] last_q;
    logic [p_size:0]   words_q;
    logic [i_size-1:0] wdata_q;

    logic              start_ok;
    logic              accept;
    logic [i_size-1:0] word;
    logic              word_ready;
    logic [p_size-1:0] last_from_len;

    assign start_ok = (state_q == StIdle) && start;
    assign accept   = rx_valid && rx_ready;

    // Oversized lengths clamp to the full memory, so the last address saturates.
    assign last_from_len = (len > MaxLen) ? {p_size{1'b1}} : p_size'(len - 1'b1);

    instr_assembler #(
        .nbytes (i_size / 8)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .accept     (accept),
        .data       (rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len == '0) ? StDone : StRecv;
                end
            end
            StRecv: begin
                if (word_ready) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = (addr_q == last_q) ? StDone : StRecv;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            last_q  <= '0;
            words_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                addr_q  <= '0;
                words_q <= '0;
                if (len != '0) begin
                    last_q <= last_from_len;
                end
            end
            // Latch the finished word so mem_wdata holds while the next one shifts in.
            if (state_q == StRecv && word_ready) begin
                wdata_q <= word;
            end
            if (state_q == StWrite) begin
                words_q <= words_q + 1'b1;
                if (addr_q != last_q) begin
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    assign rx_ready     = (state_q == StRecv);
    assign mem_we       = (state_q == StWrite);
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, fixed corner sequences and
// random loads compared against a byte-stream model of the expected writes.
module tb_prog_loader;

    localparam int P    = 6;
    localparam int I    = 24;
    localparam int B    = I / 8;
    localparam int MAXW = 1 << P;

    typedef logic [P:0] len_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [P:0]   len;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         mem_we;
    logic [P-1:0] mem_addr;
    logic [I-1:0] mem_wdata;
    logic         busy;
    logic         done;
    logic [P:0]   words_loaded;

    prog_loader #(
        .p_size (P),
        .i_size (I)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0]   src[$];
    int           got_addr[$];
    logic [I-1:0] got_data[$];
    int           got_cyc[$];
    int           done_cyc[$];
    int           hs_cyc[$];

    int           inv_bad    = 0;
    logic [I-1:0] prev_wdata = '0;
    bit           skip_hold  = 1'b1;

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(int'(mem_addr));
            got_data.push_back(mem_wdata);
            got_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (!rst) begin
            if ((busy && !mem_we && !done) != rx_ready) inv_bad++;
            if (mem_we && (done || rx_ready || !busy)) inv_bad++;
            if (!skip_hold && !mem_we && mem_wdata !== prev_wdata) inv_bad++;
        end
        skip_hold  = rst;
        prev_wdata = mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [I-1:0] model_word(input int w);
        logic [I-1:0] v = '0;
        for (int j = 0; j < B; j++) v = (v << 8) | I'(src[w * B + j]);
        return v;
    endfunction

    task automatic fill_random(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(8'($urandom));
    endtask

    task automatic drive_bytes(input int n, input bit stall, input bit poke, output bit ok);
        int k = 0;
        int w;
        bit r;
        ok = 1'b1;
        while (k < n && ok) begin
            if (stall) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                start    = poke && ($urandom_range(0, 1) == 1);
                len      = len_t'($urandom);
                @(posedge clk); #1;
            end
            rx_valid = 1'b1;
            rx_data  = src[k];
            start    = poke && ($urandom_range(0, 1) == 1);
            len      = len_t'($urandom);
            w = 0;
            forever begin
                r = rx_ready;
                @(posedge clk); #1;
                if (r) break;
                w++;
                if (w > 20) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (ok) begin
                k++;
                if (k % B == 0) hs_cyc.push_back(cyc);
            end
        end
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_load(input int l, input bit stall, input bit poke, input int exp_n,
                            input string tag);
        int  n_start;
        int  t;
        int  m;
        bit  ok;
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        done_cyc.delete(); hs_cyc.delete();
        check({tag, " idle before start"}, busy, 1'b0);
        start = 1'b1;
        len   = len_t'(l);
        @(posedge clk); #1;
        start   = 1'b0;
        n_start = cyc;
        check({tag, " busy after start"}, busy, 1'b1);
        drive_bytes(exp_n * B, stall, poke, ok);
        check({tag, " byte handshakes"}, ok, 1'b1);
        t = 0;
        while (done_cyc.size() == 0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, " done pulses"}, done_cyc.size(), 1);
        check({tag, " write count"}, got_addr.size(), exp_n);
        m = (got_addr.size() < exp_n) ? got_addr.size() : exp_n;
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), got_addr[i], i);
            check($sformatf("%s data[%0d]", tag, i), got_data[i], model_word(i));
            if (i < hs_cyc.size())
                check($sformatf("%s we latency[%0d]", tag, i), got_cyc[i], hs_cyc[i]);
        end
        if (done_cyc.size() > 0) begin
            if (exp_n == 0) check({tag, " done timing"}, done_cyc[0], n_start);
            else if (got_cyc.size() > 0)
                check({tag, " done timing"}, done_cyc[0], got_cyc[got_cyc.size() - 1] + 1);
        end
        check({tag, " words_loaded"}, words_loaded, exp_n);
        check({tag, " idle after"}, busy, 1'b0);
    endtask

    typedef struct {
        int l;
        bit stall;
        bit poke;
        int exp_n;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int l;
        vecs[0] = '{l: 2,   stall: 1'b0, poke: 1'b0, exp_n: 2};
        vecs[1] = '{l: 1,   stall: 1'b1, poke: 1'b0, exp_n: 1};
        vecs[2] = '{l: 0,   stall: 1'b0, poke: 1'b0, exp_n: 0};
        vecs[3] = '{l: 64,  stall: 1'b0, poke: 1'b0, exp_n: 64};
        vecs[4] = '{l: 100, stall: 1'b0, poke: 1'b0, exp_n: 64};
        vecs[5] = '{l: 5,   stall: 1'b1, poke: 1'b1, exp_n: 5};
        vecs[6] = '{l: 3,   stall: 1'b0, poke: 1'b1, exp_n: 3};
        vecs[7] = '{l: 127, stall: 1'b1, poke: 1'b0, exp_n: 64};

        rst = 1'b1; start = 1'b0; len = '0; rx_valid = 1'b0; rx_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset rx_ready", rx_ready, 1'b0);
        check("reset mem_we", mem_we, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset words_loaded", words_loaded, 0);

        // Reference byte streams with constant expected words.
        src = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        run_load(2, 1'b0, 1'b0, 2, "fixed2");
        if (got_data.size() >= 2) begin
            check("fixed2 word0", got_data[0], 24'h123456);
            check("fixed2 word1", got_data[1], 24'hABCDEF);
        end
        src = '{8'h12, 8'h34, 8'h56};
        run_load(1, 1'b1, 1'b0, 1, "fixed1 stall");
        if (got_data.size() >= 1) check("fixed1 word0", got_data[0], 24'h123456);

        for (int v = 0; v < 8; v++) begin
            fill_random(vecs[v].exp_n * B);
            run_load(vecs[v].l, vecs[v].stall, vecs[v].poke, vecs[v].exp_n,
                     $sformatf("vec%0d", v));
        end

        // Reset partway through the second word of a three-word load.
        got_addr.delete(); got_data.delete(); got_cyc.delete(); hs_cyc.delete();
        fill_random(9);
        start = 1'b1; len = len_t'(3);
        @(posedge clk); #1;
        start = 1'b0;
        drive_bytes(5, 1'b0, 1'b0, ok);
        check("midrst handshakes", ok, 1'b1);
        rst = 1'b1; start = 1'b1; len = len_t'(2); rx_valid = 1'b1; rx_data = 8'h5A;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
        check("midrst busy", busy, 1'b0);
        check("midrst rx_ready", rx_ready, 1'b0);
        check("midrst mem_we", mem_we, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst mem_addr", mem_addr, 0);
        check("midrst mem_wdata", mem_wdata, 0);
        check("midrst words_loaded", words_loaded, 0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst writes", got_addr.size(), 1);
        fill_random(B);
        run_load(1, 1'b0, 1'b0, 1, "reload");

        for (int r = 0; r < 6; r++) begin
            l = $urandom_range(0, 2 * MAXW - 1);
            fill_random(((l > MAXW) ? MAXW : l) * B);
            run_load(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     (l > MAXW) ? MAXW : l, $sformatf("rand%0d len%0d", r, l));
        end

        check("protocol invariants", inv_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
